// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Shares one AXI4-Lite slave port between the instruction fetch unit
//   (read-only master) and the load/store unit (read/write master). One whole
//   transaction is granted at a time and the grant is held until that
//   transaction's response handshake (R or B) completes.
//
// Ports
//   clk, rst            clock; asynchronous active-high reset
//   ifu_ar*, ifu_r*     IFU read-address / read-data channels
//   lsu_ar*, lsu_r*     LSU read-address / read-data channels
//   lsu_aw*, lsu_w*,    LSU write-address / write-data / write-response
//   lsu_b*              channels
//   s_ar*, s_r*, s_aw*, slave-side AXI4-Lite port towards memory/crossbar
//   s_w*, s_b*
module mem_bus_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,

  input  logic                ifu_arvalid,
  output logic                ifu_arready,
  input  logic [ADDR_W-1:0]   ifu_araddr,
  input  logic [2:0]          ifu_arsize,
  output logic                ifu_rvalid,
  input  logic                ifu_rready,
  output logic [DATA_W-1:0]   ifu_rdata,
  output logic [1:0]          ifu_rresp,

  input  logic                lsu_arvalid,
  output logic                lsu_arready,
  input  logic [ADDR_W-1:0]   lsu_araddr,
  input  logic [2:0]          lsu_arsize,
  output logic                lsu_rvalid,
  input  logic                lsu_rready,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic [1:0]          lsu_rresp,
  input  logic                lsu_awvalid,
  output logic                lsu_awready,
  input  logic [ADDR_W-1:0]   lsu_awaddr,
  input  logic [2:0]          lsu_awsize,
  input  logic                lsu_wvalid,
  output logic                lsu_wready,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wstrb,
  output logic                lsu_bvalid,
  input  logic                lsu_bready,
  output logic [1:0]          lsu_bresp,

  output logic                s_arvalid,
  input  logic                s_arready,
  output logic [ADDR_W-1:0]   s_araddr,
  output logic [2:0]          s_arsize,
  input  logic                s_rvalid,
  output logic                s_rready,
  input  logic [DATA_W-1:0]   s_rdata,
  input  logic [1:0]          s_rresp,
  output logic                s_awvalid,
  input  logic                s_awready,
  output logic [ADDR_W-1:0]   s_awaddr,
  output logic [2:0]          s_awsize,
  output logic                s_wvalid,
  input  logic                s_wready,
  output logic [DATA_W-1:0]   s_wdata,
  output logic [DATA_W/8-1:0] s_wstrb,
  input  logic                s_bvalid,
  output logic                s_bready,
  input  logic [1:0]          s_bresp
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IFU_RD = 2'd1,
    LSU_RD = 2'd2,
    LSU_WR = 2'd3
  } state_t;

  // Identity of the master that completed the most recent read.
  localparam logic LAST_IFU = 1'b0;
  localparam logic LAST_LSU = 1'b1;

  state_t state_r;
  logic   last_rd_r;
  logic   r_done_s;
  logic   b_done_s;

  // Response handshakes that close the current grant.
  assign r_done_s = s_rvalid & s_rready;
  assign b_done_s = s_bvalid & s_bready;

  // Read data and responses go to both masters; only the valids are gated.
  assign ifu_rdata = s_rdata;
  assign ifu_rresp = s_rresp;
  assign lsu_rdata = s_rdata;
  assign lsu_rresp = s_rresp;
  assign lsu_bresp = s_bresp;

  // Grant FSM: arbitrates in IDLE, holds the grant until the response handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      last_rd_r <= LAST_IFU;
    end else begin
      case (state_r)
        IDLE: begin
          // Writes win over reads; a read tie goes to the master that did
          // not complete the previous read.
          if (lsu_awvalid | lsu_wvalid) begin
            state_r <= LSU_WR;
          end else if (lsu_arvalid & ifu_arvalid) begin
            state_r <= (last_rd_r == LAST_IFU) ? LSU_RD : IFU_RD;
          end else if (lsu_arvalid) begin
            state_r <= LSU_RD;
          end else if (ifu_arvalid) begin
            state_r <= IFU_RD;
          end else begin
            state_r <= IDLE;
          end
        end
        IFU_RD: begin
          if (r_done_s) begin
            state_r   <= IDLE;
            last_rd_r <= LAST_IFU;
          end else begin
            state_r   <= IFU_RD;
          end
        end
        LSU_RD: begin
          if (r_done_s) begin
            state_r   <= IDLE;
            last_rd_r <= LAST_LSU;
          end else begin
            state_r   <= LSU_RD;
          end
        end
        LSU_WR: begin
          if (b_done_s) begin
            state_r <= IDLE;
          end else begin
            state_r <= LSU_WR;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Channel routing: only the granted master's channels reach the slave.
  always_comb begin
    s_arvalid   = 1'b0;
    s_araddr    = {ADDR_W{1'b0}};
    s_arsize    = 3'd0;
    s_rready    = 1'b0;
    s_awvalid   = 1'b0;
    s_awaddr    = {ADDR_W{1'b0}};
    s_awsize    = 3'd0;
    s_wvalid    = 1'b0;
    s_wdata     = {DATA_W{1'b0}};
    s_wstrb     = {(DATA_W/8){1'b0}};
    s_bready    = 1'b0;
    ifu_arready = 1'b0;
    ifu_rvalid  = 1'b0;
    lsu_arready = 1'b0;
    lsu_rvalid  = 1'b0;
    lsu_awready = 1'b0;
    lsu_wready  = 1'b0;
    lsu_bvalid  = 1'b0;
    case (state_r)
      IFU_RD: begin
        s_arvalid   = ifu_arvalid;
        s_araddr    = ifu_araddr;
        s_arsize    = ifu_arsize;
        ifu_arready = s_arready;
        ifu_rvalid  = s_rvalid;
        s_rready    = ifu_rready;
      end
      LSU_RD: begin
        s_arvalid   = lsu_arvalid;
        s_araddr    = lsu_araddr;
        s_arsize    = lsu_arsize;
        lsu_arready = s_arready;
        lsu_rvalid  = s_rvalid;
        s_rready    = lsu_rready;
      end
      LSU_WR: begin
        // AW and W pass through independently so W may trail AW.
        s_awvalid   = lsu_awvalid;
        s_awaddr    = lsu_awaddr;
        s_awsize    = lsu_awsize;
        lsu_awready = s_awready;
        s_wvalid    = lsu_wvalid;
        s_wdata     = lsu_wdata;
        s_wstrb     = lsu_wstrb;
        lsu_wready  = s_wready;
        lsu_bvalid  = s_bvalid;
        s_bready    = lsu_bready;
      end
      IDLE: begin
        s_arvalid = 1'b0;
      end
      default: begin
        s_arvalid = 1'b0;
      end
    endcase
  end

endmodule
